// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive path.
// The receive FSM state encoding lives here so checkers and benches can name it.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } rx_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous serial input.
// Flops preset to 1 so a reset line looks idle rather than like a start bit.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic rxclk,
    input  logic reset,
    input  logic rx_in,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift the raw line through the synchronizer chain.
    always_ff @(posedge rxclk or negedge reset) begin
        if (!reset) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign rx_s = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: 16x oversampled frame recovery with an unload handshake,
// framing-error and overrun reporting.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 rxclk,
    input  logic                 reset,
    input  logic                 rx_enable,
    input  logic                 rx_in,
    input  logic                 uld_rx_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_empty,
    output logic                 rx_frame_err,
    output logic                 rx_over_run,
    output logic                 rx_busy
);

    localparam int CNT_W = cnt_width(OVERSAMPLE);
    localparam int BIT_W = cnt_width(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = '0;
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_r, state_n;
    logic [CNT_W-1:0]     sample_cnt_r, sample_cnt_n;
    logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_n;
    logic [DATA_BITS-1:0] shift_r, shift_n;
    logic                 armed_r, armed_n;
    logic                 stop_hit_s;
    logic                 load_s, drop_s, unload_s;

    logic [DATA_BITS-1:0] rx_data_r, rx_data_n;
    logic                 rx_empty_r, rx_empty_n;
    logic                 rx_frame_err_r, rx_frame_err_n;
    logic                 rx_over_run_r, rx_over_run_n;
    logic                 rx_busy_r, rx_busy_n;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .rxclk (rxclk),
        .reset (reset),
        .rx_in (rx_in),
        .rx_s  (rx_s)
    );

    // Frame FSM next-state, bit timing counters and shift register.
    always_comb begin
        state_n      = state_r;
        sample_cnt_n = sample_cnt_r;
        bit_cnt_n    = bit_cnt_r;
        shift_n      = shift_r;
        stop_hit_s   = 1'b0;

        // Only an idle-high line re-arms start detection, so a held break cannot retrigger.
        if (state_r == IDLE && rx_s) begin
            armed_n = 1'b1;
        end else begin
            armed_n = armed_r;
        end

        if (!rx_enable) begin
            state_n      = IDLE;
            sample_cnt_n = CNT_ZERO;
            bit_cnt_n    = BIT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (armed_r && !rx_s) begin
                        state_n      = START;
                        sample_cnt_n = CNT_ZERO;
                        armed_n      = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                START: begin
                    if (sample_cnt_r == CNT_HALF) begin
                        sample_cnt_n = CNT_ZERO;
                        bit_cnt_n    = BIT_ZERO;
                        if (!rx_s) begin
                            state_n = DATA;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        sample_cnt_n = sample_cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (sample_cnt_r == CNT_MAX) begin
                        sample_cnt_n = CNT_ZERO;
                        shift_n      = {rx_s, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == BIT_LAST) begin
                            state_n   = STOP;
                            bit_cnt_n = BIT_ZERO;
                        end else begin
                            bit_cnt_n = bit_cnt_r + BIT_ONE;
                        end
                    end else begin
                        sample_cnt_n = sample_cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (sample_cnt_r == CNT_MAX) begin
                        sample_cnt_n = CNT_ZERO;
                        state_n      = IDLE;
                        stop_hit_s   = 1'b1;
                    end else begin
                        sample_cnt_n = sample_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_n      = IDLE;
                    sample_cnt_n = CNT_ZERO;
                    bit_cnt_n    = BIT_ZERO;
                end
            endcase
        end
    end

    assign load_s   = stop_hit_s & rx_s & (rx_empty_r | uld_rx_data);
    assign drop_s   = stop_hit_s & rx_s & ~rx_empty_r & ~uld_rx_data;
    assign unload_s = uld_rx_data & ~rx_empty_r;

    // Host-facing holding register and status flags; a load beats a same-cycle unload.
    always_comb begin
        rx_data_n      = rx_data_r;
        rx_empty_n     = rx_empty_r;
        rx_frame_err_n = rx_frame_err_r;
        rx_over_run_n  = rx_over_run_r;
        rx_busy_n      = (state_n != IDLE);

        if (load_s) begin
            rx_data_n  = shift_r;
            rx_empty_n = 1'b0;
        end else if (unload_s) begin
            rx_empty_n = 1'b1;
        end else begin
            rx_empty_n = rx_empty_r;
        end

        if (unload_s) begin
            rx_over_run_n = 1'b0;
        end else if (drop_s) begin
            rx_over_run_n = 1'b1;
        end else begin
            rx_over_run_n = rx_over_run_r;
        end

        if (stop_hit_s) begin
            rx_frame_err_n = ~rx_s;
        end else begin
            rx_frame_err_n = rx_frame_err_r;
        end
    end

    // Frame FSM state, counters, shift register and arm flag.
    always_ff @(posedge rxclk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            sample_cnt_r <= CNT_ZERO;
            bit_cnt_r    <= BIT_ZERO;
            shift_r      <= '0;
            armed_r      <= 1'b0;
        end else begin
            state_r      <= state_n;
            sample_cnt_r <= sample_cnt_n;
            bit_cnt_r    <= bit_cnt_n;
            shift_r      <= shift_n;
            armed_r      <= armed_n;
        end
    end

    // Registered host-side outputs.
    always_ff @(posedge rxclk or negedge reset) begin
        if (!reset) begin
            rx_data_r      <= '0;
            rx_empty_r     <= 1'b1;
            rx_frame_err_r <= 1'b0;
            rx_over_run_r  <= 1'b0;
            rx_busy_r      <= 1'b0;
        end else begin
            rx_data_r      <= rx_data_n;
            rx_empty_r     <= rx_empty_n;
            rx_frame_err_r <= rx_frame_err_n;
            rx_over_run_r  <= rx_over_run_n;
            rx_busy_r      <= rx_busy_n;
        end
    end

    assign rx_data      = rx_data_r;
    assign rx_empty     = rx_empty_r;
    assign rx_frame_err = rx_frame_err_r;
    assign rx_over_run  = rx_over_run_r;
    assign rx_busy      = rx_busy_r;

endmodule
